// File: rtl/tpu_stream_host.sv
// ---------------------------------------------------------------------------
// tpu_stream_host
//   Host-side sequencer for the byte-wide tt_um_tpu pin interface.
//   Loads a DIM x DIM weight matrix (optional) and a DIM x DIM input matrix
//   from a valid/ready byte stream into the TPU. It then waits out the compute
//   latency and reads DIM*DIM results back byte-serially into a local buffer.
//   Finally it streams the results out row-major on a valid/ready port.
//
//   Handshake rule (both streams): a transfer happens on a rising clock edge
//   where valid and ready are both high. valid never depends on ready. Once
//   raised, res_valid and res_data stay stable until the transfer happens.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, mode        job request (IDLE only); mode 1 reuses loaded weights
//   abort              synchronous return to IDLE, no done
//   a_data/a_valid/    element byte stream in
//   a_ready
//   tpu_ui             TPU ui_in  : element byte
//   tpu_uio            TPU uio_in : [0] load_en, [1] sel (1 = X), [2] out_req
//   tpu_uo             TPU uo_out : result bytes
//   res_data/res_valid result word stream out
//   /res_ready
//   busy, done, err    status: not idle / job finished / reuse without weights
//   fsm_state          current FSM state encoding, for observation
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tpu_stream_host #(
    parameter int DIM         = 2,
    parameter int OUT_W       = 16,
    parameter int COMPUTE_LAT = 4,
    parameter int RD_LAT      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [7:0]       a_data,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [7:0]       tpu_ui,
    output logic [7:0]       tpu_uio,
    input  logic [7:0]       tpu_uo,
    output logic [OUT_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       fsm_state
);

    localparam int NE  = DIM * DIM;          // elements per matrix
    localparam int BPW = OUT_W / 8;          // bytes per result word
    localparam int NB  = NE * BPW;           // result bytes per job
    localparam int IW  = (NE  > 1) ? $clog2(NE)  : 1;
    localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int RW  = $clog2(NB + 1);     // request counter must reach NB
    localparam int WW  = (COMPUTE_LAT > 1) ? $clog2(COMPUTE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_X = 3'd2,
        S_WAIT   = 3'd3,
        S_READ   = 3'd4,
        S_EMIT   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IW-1:0]    elem_cnt;              // load count, then emit index
    logic [WW-1:0]    wait_cnt;
    logic [RW-1:0]    req_cnt;
    logic [IW-1:0]    cap_word;
    logic [LW-1:0]    cap_lane;
    logic [RD_LAT-1:0] rd_pipe;              // bit RD_LAT-1 high: byte on tpu_uo now
    logic             wts_loaded;
    logic             load_q;
    logic             sel_q;

    logic [OUT_W-1:0] buf_mem [NE];

    logic accept;
    logic last_elem;
    logic wait_done;
    logic req_active;
    logic cap_en;
    logic cap_last;
    logic res_hs;
    logic err_set;
    logic done_set;

    assign accept     = a_valid & a_ready;
    assign last_elem  = (elem_cnt == IW'(NE - 1));
    assign wait_done  = (wait_cnt == WW'(COMPUTE_LAT - 1));
    assign req_active = (state == S_READ) && (req_cnt != RW'(NB));
    assign cap_en     = (state == S_READ) && rd_pipe[RD_LAT-1];
    assign cap_last   = cap_en && (cap_word == IW'(NE - 1)) && (cap_lane == LW'(BPW - 1));
    assign res_hs     = res_valid & res_ready;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        done_set  = 1'b0;
        a_ready   = 1'b0;
        res_valid = 1'b0;
        busy      = (state != S_IDLE);

        case (state)
            S_LOAD_W, S_LOAD_X: a_ready   = 1'b1;
            S_EMIT:             res_valid = 1'b1;
            default: ;
        endcase

        if (abort) begin
            // abort wins over start and over any completion this cycle
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!mode)           state_nxt = S_LOAD_W;
                        else if (wts_loaded) state_nxt = S_LOAD_X;
                        else                 err_set   = 1'b1;
                    end
                end
                S_LOAD_W: if (accept && last_elem) state_nxt = S_LOAD_X;
                S_LOAD_X: if (accept && last_elem) state_nxt = S_WAIT;
                S_WAIT:   if (wait_done)           state_nxt = S_READ;
                S_READ:   if (cap_last)            state_nxt = S_EMIT;
                S_EMIT: begin
                    if (res_hs && last_elem) begin
                        state_nxt = S_IDLE;
                        done_set  = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Counters, TPU pin registers, status pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt   <= '0;
            wait_cnt   <= '0;
            req_cnt    <= '0;
            cap_word   <= '0;
            cap_lane   <= '0;
            rd_pipe    <= '0;
            wts_loaded <= 1'b0;
            load_q     <= 1'b0;
            sel_q      <= 1'b0;
            tpu_ui     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= done_set;
            err  <= err_set;

            // Element byte goes to the pins the cycle after it is accepted;
            // tpu_ui keeps the last byte, sel is only asserted with load_en.
            load_q <= accept && !abort;
            sel_q  <= accept && !abort && (state == S_LOAD_X);
            if (accept && !abort) begin
                tpu_ui <= a_data;
            end

            // Read-latency tracker: one bit per outstanding request.
            rd_pipe[0] <= req_active && !abort;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1] && !abort;
            end

            if (abort && (state == S_LOAD_W)) begin
                wts_loaded <= 1'b0;
            end else if ((state == S_LOAD_W) && accept && last_elem && !abort) begin
                wts_loaded <= 1'b1;
            end

            // Every state change starts the next phase with clean counters.
            if (state_nxt != state) begin
                elem_cnt <= '0;
                wait_cnt <= '0;
                req_cnt  <= '0;
                cap_word <= '0;
                cap_lane <= '0;
            end else begin
                case (state)
                    S_LOAD_W, S_LOAD_X: if (accept) elem_cnt <= elem_cnt + 1'b1;
                    S_WAIT:             wait_cnt <= wait_cnt + 1'b1;
                    S_READ: begin
                        if (req_active) req_cnt <= req_cnt + 1'b1;
                        if (cap_en) begin
                            if (cap_lane == LW'(BPW - 1)) begin
                                cap_lane <= '0;
                                cap_word <= cap_word + 1'b1;
                            end else begin
                                cap_lane <= cap_lane + 1'b1;
                            end
                        end
                    end
                    S_EMIT:  if (res_hs) elem_cnt <= elem_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Result buffer: bytes arrive LSB first, lane by lane within a word.
    // Contents are not reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int l = 0; l < BPW; l++) begin
                if (cap_lane == LW'(l)) begin
                    buf_mem[cap_word][l*8 +: 8] <= tpu_uo;
                end
            end
        end
    end

    assign res_data  = (state == S_EMIT) ? buf_mem[elem_cnt] : '0;
    assign tpu_uio   = {5'b00000, req_active, sel_q, load_q};
    assign fsm_state = state;

endmodule

// File: tb/tb_tpu_stream_host.sv
`timescale 1ns/1ps
module tb_tpu_stream_host;

    localparam int DIM   = 2;
    localparam int OUT_W = 16;
    localparam int CLAT  = 4;
    localparam int RLAT  = 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clk;
    logic             rst;
    logic             start;
    logic             mode;
    logic             abort;
    logic [7:0]       a_data;
    logic             a_valid;
    logic             a_ready;
    logic [7:0]       tpu_ui;
    logic [7:0]       tpu_uio;
    logic [7:0]       tpu_uo;
    logic [OUT_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       fsm_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    tpu_stream_host #(
        .DIM(DIM), .OUT_W(OUT_W), .COMPUTE_LAT(CLAT), .RD_LAT(RLAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .tpu_ui(tpu_ui), .tpu_uio(tpu_uio), .tpu_uo(tpu_uo),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .err(err), .fsm_state(fsm_state)
    );

    // ---------------- TPU pin model: C = X * W, one-cycle read latency ----
    logic [7:0] wm [4];
    logic [7:0] xm [4];
    int         wi, xi, ri;

    function automatic logic [15:0] c_word(input int idx);
        int r, c;
        logic [15:0] s;
        r = idx / 2;
        c = idx % 2;
        s = 16'(xm[r*2] * wm[c]) + 16'(xm[r*2+1] * wm[2+c]);
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [15:0] w;
        if (rst) begin
            tpu_uo <= 8'h00;
            wi = 0; xi = 0; ri = 0;
        end else if (!busy) begin
            wi = 0; xi = 0; ri = 0;
        end else begin
            if (tpu_uio[0]) begin
                if (tpu_uio[1]) begin
                    if (xi < 4) xm[xi] = tpu_ui;
                    xi++;
                end else begin
                    if (wi < 4) wm[wi] = tpu_ui;
                    wi++;
                end
            end
            if (tpu_uio[2]) begin
                w = c_word((ri / 2) % 4);
                tpu_uo <= (ri % 2 == 1) ? w[15:8] : w[7:0];
                ri++;
            end
        end
    end

    // ---------------- monitor (sampled on the falling edge) ----------------
    logic [OUT_W-1:0] got_q[$];
    int load_cnt = 0, sel0_cnt = 0, done_cnt = 0, err_cnt = 0;
    int busy_cnt = 0, uio_nz_cnt = 0, rv_cnt = 0, stall_err = 0;
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (tpu_uio[0]) load_cnt++;
            if (tpu_uio[0] && !tpu_uio[1]) sel0_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (busy) busy_cnt++;
            if (tpu_uio != 8'h00) uio_nz_cnt++;
            if (res_valid) rv_cnt++;
            if (prev_stall && res_valid && (res_data != prev_data)) stall_err++;
            if (res_valid && res_ready) got_q.push_back(res_data);
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
        end
    end

    // ---------------- scoreboard / checking ----------------
    logic [OUT_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int s_load, s_sel0, s_done, s_err, s_busy, s_nz, s_rv, s_stall, got_base;

    task automatic snap();
        s_load = load_cnt; s_sel0 = sel0_cnt; s_done = done_cnt; s_err = err_cnt;
        s_busy = busy_cnt; s_nz = uio_nz_cnt; s_rv = rv_cnt; s_stall = stall_err;
        got_base = got_q.size();
    endtask

    task automatic check_results(input string tag);
        logic [31:0] g;
        int n;
        n = exp_q.size();
        check({tag, "_count"}, 32'(got_q.size() - got_base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (got_base + i < got_q.size()) g = 32'(got_q[got_base + i]);
            else                             g = 32'hDEAD_BEEF;
            check($sformatf("%s_res%0d", tag, i), g, 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks ----------------
    logic [7:0] stim [8];

    task automatic start_job(input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int acc;
        acc = 0;
        for (int e = 0; e < n; e++) begin
            if (gaps) begin
                a_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            a_valid = 1'b1;
            a_data  = stim[e];
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (a_ready) begin
                    @(posedge clk); #1;
                    acc++;
                    break;
                end
            end
        end
        a_valid = 1'b0;
        check("feed_accepts", 32'(acc), 32'(n));
    endtask

    task automatic drain(input int n, input bit toggle);
        for (int t = 0; t < 300 && (got_q.size() - got_base) < n; t++) begin
            res_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        a_data = 8'h00; a_valid = 1'b0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 32'({tpu_ui, tpu_uio, a_ready, res_valid, busy, done, err}), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: full job, W=[1,2;3,4], X=[5,6;7,8]
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_q.push_back(16'd23); exp_q.push_back(16'd34);
        exp_q.push_back(16'd31); exp_q.push_back(16'd46);
        snap();
        start_job(1'b0);
        feed(8, 1'b0);
        drain(4, 1'b0);
        check_results("t1");
        check("t1_done", 32'(done_cnt - s_done), 32'd1);
        check("t1_load_cycles", 32'(load_cnt - s_load), 32'd8);
        check("t1_busy_end", 32'(busy), 32'd0);

        // 2: weight reuse, X = identity
        stim = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_q.push_back(16'd1); exp_q.push_back(16'd2);
        exp_q.push_back(16'd3); exp_q.push_back(16'd4);
        snap();
        start_job(1'b1);
        feed(4, 1'b0);
        drain(4, 1'b0);
        check_results("t2");
        check("t2_sel0_loads", 32'(sel0_cnt - s_sel0), 32'd0);
        check("t2_load_cycles", 32'(load_cnt - s_load), 32'd4);
        check("t2_done", 32'(done_cnt - s_done), 32'd1);

        // 3: reset, then reuse without weights
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        snap();
        start_job(1'b1);
        repeat (4) begin @(posedge clk); #1; end
        check("t3_err", 32'(err_cnt - s_err), 32'd1);
        check("t3_busy", 32'(busy_cnt - s_busy), 32'd0);
        check("t3_uio", 32'(uio_nz_cnt - s_nz), 32'd0);

        // 4: job 1 again with input gaps and consumer back-pressure
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_q.push_back(16'd23); exp_q.push_back(16'd34);
        exp_q.push_back(16'd31); exp_q.push_back(16'd46);
        snap();
        start_job(1'b0);
        feed(8, 1'b1);
        drain(4, 1'b1);
        check_results("t4");
        check("t4_stable", 32'(stall_err - s_stall), 32'd0);
        check("t4_done", 32'(done_cnt - s_done), 32'd1);

        // 5: abort in the third read cycle, then a reuse job
        snap();
        start_job(1'b0);
        feed(8, 1'b0);
        begin
            int seen;
            seen = 0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (tpu_uio[2]) begin seen = 1; break; end
            end
            check("t5_read_seen", 32'(seen), 32'd1);
        end
        @(posedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5_idle", 32'(fsm_state), 32'd0);
        check("t5_uio", 32'(tpu_uio), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        repeat (8) begin @(posedge clk); #1; end
        check("t5_no_valid", 32'(rv_cnt - s_rv), 32'd0);
        check("t5_no_done", 32'(done_cnt - s_done), 32'd0);

        // W still [1,2;3,4]; X=[2,1;1,3] -> [5,8;10,14]
        stim = '{8'd2, 8'd1, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_q.push_back(16'd5);  exp_q.push_back(16'd8);
        exp_q.push_back(16'd10); exp_q.push_back(16'd14);
        snap();
        start_job(1'b1);
        feed(4, 1'b0);
        drain(4, 1'b0);
        check_results("t5b");
        check("t5b_done", 32'(done_cnt - s_done), 32'd1);

        // 6: asynchronous reset in the middle of LOAD_X
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        start_job(1'b0);
        feed(5, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("t6_rst_outs", 32'({tpu_ui, tpu_uio, a_ready, res_valid, busy, done, err}), 32'd0);
        check("t6_rst_state", 32'(fsm_state), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        snap();
        start_job(1'b1);
        repeat (4) begin @(posedge clk); #1; end
        check("t6_err", 32'(err_cnt - s_err), 32'd1);
        check("t6_busy", 32'(busy_cnt - s_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
